// File: rtl/irq_sched.sv
// Machine-mode interrupt scheduler: synchronises and registers interrupt sources,
// arbitrates MEI > MSI > MTI, tracks a trap through request/handler, and measures ack latency.
module irq_sched #(
    parameter int RSZ    = 32,
    parameter int LAT_SZ = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ext_irq_in,
    input  logic              timer_irq_in,
    input  logic              sw_irq_in,
    input  logic [2:0]        mie_bits,
    input  logic              mstatus_mie,
    input  logic [1:0]        mode,
    input  logic              irq_ack,
    input  logic              mret,
    output logic              irq_req,
    output logic [RSZ-1:0]    irq_cause,
    output logic [2:0]        mip_bits,
    output logic              in_handler,
    output logic [LAT_SZ-1:0] irq_lat
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                ext_meta_r;
    logic [2:0]          mip_r;
    logic [2:0]          pend_s;
    logic                gen_s;
    logic                fire_s;
    logic [3:0]          code_s;
    logic [LAT_SZ-1:0]   lat_cnt_r;
    logic [LAT_SZ-1:0]   lat_inc_s;
    logic                irq_req_r;
    logic                in_handler_r;
    logic [RSZ-1:0]      cause_r;
    logic [LAT_SZ-1:0]   irq_lat_r;

    assign irq_req    = irq_req_r;
    assign irq_cause  = cause_r;
    assign mip_bits   = mip_r;
    assign in_handler = in_handler_r;
    assign irq_lat    = irq_lat_r;

    // Pending/enable qualification, fixed-priority cause selection and saturating latency step.
    always_comb begin
        pend_s = mip_r & mie_bits;
        gen_s  = (mode != 2'd3) | mstatus_mie;
        fire_s = gen_s & (|pend_s);
        code_s = 4'd0;
        if (pend_s[2]) begin
            code_s = 4'd11;
        end else if (pend_s[0]) begin
            code_s = 4'd3;
        end else if (pend_s[1]) begin
            code_s = 4'd7;
        end else begin
            code_s = 4'd0;
        end
        if (&lat_cnt_r) begin
            lat_inc_s = lat_cnt_r;
        end else begin
            lat_inc_s = lat_cnt_r + {{(LAT_SZ-1){1'b0}}, 1'b1};
        end
    end

    // Trap lifecycle next-state: an ack outranks a withdrawal in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) state_next_s = ST_REQ;
                else        state_next_s = ST_IDLE;
            end
            ST_REQ: begin
                if (irq_ack)      state_next_s = ST_HANDLER;
                else if (!fire_s) state_next_s = ST_IDLE;
                else              state_next_s = ST_REQ;
            end
            ST_HANDLER: begin
                if (mret) state_next_s = ST_IDLE;
                else      state_next_s = ST_HANDLER;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Synchroniser, pending register, registered outputs and latency counter.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            ext_meta_r   <= 1'b0;
            mip_r        <= 3'b000;
            irq_req_r    <= 1'b0;
            in_handler_r <= 1'b0;
            cause_r      <= {RSZ{1'b0}};
            lat_cnt_r    <= {LAT_SZ{1'b0}};
            irq_lat_r    <= {LAT_SZ{1'b0}};
        end else begin
            ext_meta_r   <= ext_irq_in;
            mip_r        <= {ext_meta_r, timer_irq_in, sw_irq_in};
            irq_req_r    <= (state_next_s == ST_REQ);
            in_handler_r <= (state_next_s == ST_HANDLER);
            if ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) begin
                cause_r   <= {1'b1, {(RSZ-5){1'b0}}, code_s};
                lat_cnt_r <= {LAT_SZ{1'b0}};
            end else if (state_r == ST_REQ) begin
                lat_cnt_r <= lat_inc_s;
                if (state_next_s == ST_HANDLER) begin
                    irq_lat_r <= lat_inc_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: a behavioural model (input history + trap bookkeeping)
// is compared every cycle, plus literal expectations for the key scenarios.
module tb_irq_sched;
    localparam int RSZ    = 32;
    localparam int LAT_SZ = 8;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              ext_irq_in, timer_irq_in, sw_irq_in;
    logic [2:0]        mie_bits;
    logic              mstatus_mie;
    logic [1:0]        mode;
    logic              irq_ack, mret;
    logic              irq_req;
    logic [RSZ-1:0]    irq_cause;
    logic [2:0]        mip_bits;
    logic              in_handler;
    logic [LAT_SZ-1:0] irq_lat;

    always #5 clk_in = ~clk_in;

    irq_sched #(.RSZ(RSZ), .LAT_SZ(LAT_SZ)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .ext_irq_in(ext_irq_in),
        .timer_irq_in(timer_irq_in), .sw_irq_in(sw_irq_in), .mie_bits(mie_bits),
        .mstatus_mie(mstatus_mie), .mode(mode), .irq_ack(irq_ack), .mret(mret),
        .irq_req(irq_req), .irq_cause(irq_cause), .mip_bits(mip_bits),
        .in_handler(in_handler), .irq_lat(irq_lat)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: what the DUT shows after each edge.
    logic        m_ext_prev = 1'b0;
    logic [2:0]  m_mip = 3'b000;
    bit          requesting = 1'b0;
    bit          handling = 1'b0;
    logic [31:0] m_cause = 32'h0;
    int          wait_cycles = 0;
    int          m_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Priority order listed as data: bit index and cause code, highest first.
    function automatic logic [31:0] cause_of(input logic [2:0] p);
        int pri_bit [3] = '{2, 0, 1};
        int pri_code[3] = '{11, 3, 7};
        for (int i = 0; i < 3; i++) begin
            if (p[pri_bit[i]]) return 32'h8000_0000 | pri_code[i];
        end
        return 32'h0;
    endfunction

    always @(posedge clk_in) begin
        logic [2:0] pend;
        bit         fire;
        if (reset_in) begin
            m_ext_prev = 1'b0; m_mip = 3'b000; requesting = 1'b0; handling = 1'b0;
            m_cause = 32'h0; wait_cycles = 0; m_lat = 0;
        end else begin
            pend = m_mip & mie_bits;
            fire = ((mode != 2'd3) || mstatus_mie) && (pend != 3'b000);
            if (handling) begin
                if (mret) handling = 1'b0;
            end else if (requesting) begin
                wait_cycles++;
                if (irq_ack) begin
                    requesting = 1'b0;
                    handling   = 1'b1;
                    m_lat      = (wait_cycles > 255) ? 255 : wait_cycles;
                end else if (!fire) begin
                    requesting = 1'b0;
                end
            end else if (fire) begin
                requesting  = 1'b1;
                wait_cycles = 0;
                m_cause     = cause_of(pend);
            end
            m_mip      = {m_ext_prev, timer_irq_in, sw_irq_in};
            m_ext_prev = ext_irq_in;
        end
    end

    always @(negedge clk_in) begin
        if (check_en) begin
            check("model irq_req",    {31'h0, irq_req},    {31'h0, requesting});
            check("model in_handler", {31'h0, in_handler}, {31'h0, handling});
            check("model irq_cause",  irq_cause,           m_cause);
            check("model mip_bits",   {29'h0, mip_bits},   {29'h0, m_mip});
            check("model irq_lat",    {24'h0, irq_lat},    m_lat);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic finish_handler();
        ext_irq_in = 1'b0; timer_irq_in = 1'b0; sw_irq_in = 1'b0;
        tick(3);
        mret = 1'b1; tick(1); mret = 1'b0;
        tick(2);
        check("idle after mret", {30'h0, irq_req, in_handler}, 32'h0);
    endtask

    initial begin
        reset_in = 1'b1; ext_irq_in = 1'b0; timer_irq_in = 1'b0; sw_irq_in = 1'b0;
        mie_bits = 3'b000; mstatus_mie = 1'b1; mode = 2'd3; irq_ack = 1'b0; mret = 1'b0;
        tick(2);
        check("reset outputs", {irq_req, in_handler, mip_bits, irq_lat}, 32'h0);
        check("reset cause", irq_cause, 32'h0);
        reset_in = 1'b0;
        check_en = 1'b1;

        // Timer trap: request at cycle 2, ack at cycle 5 -> latency 4.
        mie_bits = 3'b010;
        timer_irq_in = 1'b1;
        tick(1);
        check("timer req cycle1", {31'h0, irq_req}, 32'h0);
        tick(1);
        check("timer req cycle2", {31'h0, irq_req}, 32'h1);
        check("timer cause", irq_cause, 32'h8000_0007);
        tick(3);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("timer in_handler", {31'h0, in_handler}, 32'h1);
        check("timer lat", {24'h0, irq_lat}, 32'd4);
        finish_handler();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        tick(1);
        check("ack ignored in idle", {31'h0, in_handler}, 32'h0);

        // All sources pending, gated until mstatus_mie rises.
        mie_bits = 3'b111; mstatus_mie = 1'b0;
        ext_irq_in = 1'b1; timer_irq_in = 1'b1; sw_irq_in = 1'b1;
        tick(3);
        check("all mip", {29'h0, mip_bits}, 32'h7);
        check("gated req", {31'h0, irq_req}, 32'h0);
        mstatus_mie = 1'b1;
        tick(1);
        check("all req", {31'h0, irq_req}, 32'h1);
        check("all cause MEI", irq_cause, 32'h8000_000B);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("first-cycle ack lat", {24'h0, irq_lat}, 32'd1);
        ext_irq_in = 1'b0;
        tick(3);
        mret = 1'b1; tick(1); mret = 1'b0;
        check("no back-to-back req", {31'h0, irq_req}, 32'h0);
        tick(1);
        check("rearb cause MSI", irq_cause, 32'h8000_0003);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        ext_irq_in = 1'b1;
        tick(3);
        mret = 1'b1; tick(1); mret = 1'b0;
        tick(1);
        check("rearb cause MEI", irq_cause, 32'h8000_000B);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        finish_handler();

        // Machine mode with MIE=0 blocks; dropping to user mode enables.
        mstatus_mie = 1'b0; mie_bits = 3'b001; sw_irq_in = 1'b1;
        tick(4);
        check("mmode blocked", {31'h0, irq_req}, 32'h0);
        mode = 2'd0;
        tick(2);
        check("umode req", {31'h0, irq_req}, 32'h1);
        check("umode cause", irq_cause, 32'h8000_0003);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        finish_handler();
        mode = 2'd3; mstatus_mie = 1'b1;

        // Withdrawal keeps irq_lat; ack in the drop cycle still wins.
        mie_bits = 3'b010; timer_irq_in = 1'b1;
        tick(2);
        check("wd req", {31'h0, irq_req}, 32'h1);
        timer_irq_in = 1'b0;
        tick(2);
        check("wd req dropped", {31'h0, irq_req}, 32'h0);
        check("wd lat held", {24'h0, irq_lat}, 32'd2);
        timer_irq_in = 1'b1;
        tick(2);
        timer_irq_in = 1'b0;
        tick(1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("ack beats withdraw", {31'h0, in_handler}, 32'h1);
        finish_handler();

        // Long wait saturates latency.
        timer_irq_in = 1'b1;
        tick(302);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("sat lat", {24'h0, irq_lat}, 32'h0000_00FF);
        finish_handler();

        // Reset during handler, external source still asserted.
        mie_bits = 3'b100; ext_irq_in = 1'b1;
        tick(3);
        check("ext req", {31'h0, irq_req}, 32'h1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        check("ext in_handler", {31'h0, in_handler}, 32'h1);
        reset_in = 1'b1; tick(1); reset_in = 1'b0;
        check("post-reset flags", {irq_req, in_handler, mip_bits, irq_lat}, 32'h0);
        check("post-reset cause", irq_cause, 32'h0);
        tick(2);
        check("post-reset quiet", {31'h0, irq_req}, 32'h0);
        tick(1);
        check("post-reset ext req", {31'h0, irq_req}, 32'h1);
        check("post-reset ext cause", irq_cause, 32'h8000_000B);
        tick(2);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_sched.md
IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 SHALL have parameter RSZ, default 32, meaning the width of the cause output.
REQ-002 SHALL have parameter LAT_SZ, default 8, meaning the width of the latency counter.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ext_irq_in, input, 1 bit: asynchronous level machine external interrupt.
REQ-006 SHALL have port timer_irq_in, input, 1 bit: synchronous level machine timer interrupt.
REQ-007 SHALL have port sw_irq_in, input, 1 bit: synchronous level machine software interrupt.
REQ-008 SHALL have port mie_bits, input, 3 bits: enables {meie, mtie, msie}.
REQ-009 SHALL have port mstatus_mie, input, 1 bit: machine global interrupt enable.
REQ-010 SHALL have port mode, input, 2 bits: current privilege mode, where 3 = Machine.
REQ-011 SHALL have port irq_ack, input, 1 bit: WB stage has taken the trap this cycle.
REQ-012 SHALL have port mret, input, 1 bit: an MRET retires this cycle.
REQ-013 SHALL have port irq_req, output, 1 bit: interrupt request to the WB stage.
REQ-014 SHALL have port irq_cause, output, RSZ bits: mcause value with the interrupt bit set.
REQ-015 SHALL have port mip_bits, output, 3 bits: pending bits {meip, mtip, msip}.
REQ-016 SHALL have port in_handler, output, 1 bit: a trap has been taken and its MRET has not yet occurred.
REQ-017 SHALL have port irq_lat, output, LAT_SZ bits: cycles from request to acknowledge for the last trap.

Function
REQ-018 SHALL pass ext_irq_in through a 2-flop synchronizer, giving meip as the second flop's output.
REQ-019 SHALL set mip_bits as follows: mip_bits = {meip, timer_irq_in, sw_irq_in}, registered, so each bit appears 1 cycle after its source, or 2 cycles for meip.
REQ-020 SHALL compute pend = mip_bits & mie_bits.
REQ-021 SHALL compute gen = (mode != 3) | mstatus_mie.
REQ-022 SHALL compute fire = gen & |pend.
REQ-023 SHALL fix the interrupt priority as MEI > MSI > MTI, with causes 11, 3 and 7 respectively.
REQ-024 SHALL set irq_cause = {1'b1, zeros, code[3:0]}, where code comes from the winning pending interrupt.
REQ-025 SHALL implement FSM states IDLE, REQ and HANDLER.
REQ-026 SHALL transition IDLE->REQ when fire=1, latching the winning code into irq_cause on the same edge.
REQ-027 SHALL stay in IDLE when fire=0.
REQ-028 SHALL assert irq_req=1 exactly while in state REQ.
REQ-029 SHALL hold irq_cause stable throughout REQ and HANDLER, even if a higher-priority interrupt becomes pending.
REQ-030 SHALL transition REQ->HANDLER when irq_ack=1.
REQ-031 SHALL transition REQ->IDLE (withdraw) when irq_ack=0 and fire=0.
REQ-032 SHALL stay in REQ when irq_ack=0 and fire=1.
REQ-033 SHALL give priority to irq_ack when irq_ack=1 and fire=0 occur in the same cycle: the FSM goes to HANDLER.
REQ-034 SHALL transition HANDLER->IDLE on mret=1; from IDLE, re-arbitration occurs on the next cycle, so there is no back-to-back REQ from HANDLER.
REQ-035 SHALL ignore irq_ack in IDLE and HANDLER.
REQ-036 SHALL ignore mret in IDLE and REQ.
REQ-037 SHALL assert in_handler=1 exactly while in state HANDLER.
REQ-038 SHALL clear a LAT_SZ latency counter on IDLE->REQ, increment it each cycle in REQ, and saturate it at all-ones with no wrap.
REQ-039 SHALL copy the latency counter into irq_lat on REQ->HANDLER, counting the ack cycle, so an ack on the first REQ cycle gives irq_lat=1.
REQ-040 SHALL hold irq_lat unchanged on a withdrawal.
REQ-041 SHALL ensure the latency from a synchronous source (timer/sw) rising with gen=1 to irq_req=1 is exactly 2 cycles.
REQ-042 SHALL ensure the latency from ext_irq_in rising to irq_req=1 is exactly 3 cycles.

Reset
REQ-043 SHALL, while reset_in=1 at a clock edge, set state to IDLE and force irq_req=0, irq_cause=0, mip_bits=0, in_handler=0, irq_lat=0, the synchronizer flops to 0 and the latency counter to 0.
REQ-044 SHALL, when reset is asserted mid-REQ or mid-HANDLER, abandon the trap with no irq_req pulse after the reset edge.
REQ-045 SHALL begin arbitration on the first cycle after reset_in deasserts.

Verification
REQ-046 The bench SHALL cover: mode=3, mstatus_mie=1, mie_bits=3'b010, timer_irq_in rises at cycle 0 -> irq_req=1 at cycle 2, irq_cause=32'h8000_0007; irq_ack at cycle 5 -> in_handler=1 at cycle 6, irq_lat=4.
REQ-047 The bench SHALL cover: all three sources pending, all enabled -> irq_cause=32'h8000_000B; ack then mret -> next cause is 32'h8000_0003 with ext still enabled only if meip cleared, else 32'h8000_000B again.
REQ-048 The bench SHALL cover: mode=3, mstatus_mie=0, sw pending and enabled -> irq_req stays 0; switch mode to 0 -> irq_req=1 two cycles later, cause 32'h8000_0003.
REQ-049 The bench SHALL cover: in REQ, drop timer_irq_in with irq_ack=0 -> IDLE next cycle, irq_req=0, irq_lat unchanged; same scenario with irq_ack=1 in the drop cycle -> HANDLER.
REQ-050 The bench SHALL cover: hold irq_ack=0 for 300 cycles in REQ, then ack -> irq_lat=8'hFF.
REQ-051 The bench SHALL cover: assert reset_in for 1 cycle while in HANDLER -> all outputs 0 on the next cycle; with ext_irq_in still high, irq_req=1 three cycles after reset deasserts.
